serial_word_receiver: RTL and testbench

Receives framed serial words and rebuilds them as parallel words, forming the receive side of the team's serial shift-register link. A frame is one start bit (0), WIDTH data bits, and one stop bit (1), sampled only on bit-strobe cycles. Each completed word is presented on a registered valid/ready output port. The block flags frame errors and overruns and recovers from a line break by itself.

---
 rtl/serial_word_receiver.sv | 194 +++++++++++++++++++
 tb/tb_serial_word_receiver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_receiver
// Description : Receive side of the serial shift-register link. Recovers
//               framed serial words (start bit 0, WIDTH data bits, stop bit 1)
//               sampled on bit-strobe edges and presents each completed word
//               on a registered valid/ready output port. Flags frame errors
//               and overruns, and rides out a line break without help.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       data bits per frame (must be >= 2)
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-low reset
//   serial_in   serial line, idles high
//   bit_en      bit strobe; serial_in is only looked at when this is 1
//   lsb_first   1 = LSB arrives first, 0 = MSB arrives first (latched per frame)
//   parallel_Q  received word, stable while out_valid = 1
//   out_valid   parallel_Q holds an unconsumed word
//   out_ready   consumer takes the word when out_valid & out_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: completed word dropped, output still full
//   busy        receiver is anywhere but IDLE
// ============================================================================
module serial_word_receiver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_en,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] parallel_Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   shift_r;
    logic               mode_r;     // frame-wide copy of lsb_first
    logic [WIDTH-1:0]   q_r;
    logic               valid_r;
    logic               frame_err_r;
    logic               overrun_r;
    logic               busy_r;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic [WIDTH-1:0]   shift_nx;
    logic               mode_nx;
    logic [WIDTH-1:0]   q_nx;
    logic               valid_nx;
    logic               frame_err_nx;
    logic               overrun_nx;
    logic               busy_nx;
    logic               word_done;  // good stop bit sampled this edge

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        shift_nx     = shift_r;
        mode_nx      = mode_r;
        q_nx         = q_r;
        valid_nx     = valid_r;
        frame_err_nx = 1'b0;
        overrun_nx   = 1'b0;
        word_done    = 1'b0;

        case (state_r)
            IDLE: begin
                if (bit_en && !serial_in) begin
                    mode_nx  = lsb_first;
                    cnt_nx   = '0;
                    state_nx = DATA;
                end
            end

            DATA: begin
                if (bit_en) begin
                    if (mode_r) begin
                        shift_nx = {serial_in, shift_r[WIDTH-1:1]};
                    end else begin
                        shift_nx = {shift_r[WIDTH-2:0], serial_in};
                    end
                    // The counter holds at its last value instead of
                    // wrapping; the last data bit is taken when it already
                    // reads WIDTH-1, so WIDTH bits are shifted in total.
                    if (cnt_r == CNT_LAST) begin
                        state_nx = STOP;
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end
            end

            STOP: begin
                if (bit_en) begin
                    if (serial_in) begin
                        word_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = BREAK;
                    end
                end
            end

            BREAK: begin
                // Wait for the line to return high; a low here is not a start.
                if (bit_en && serial_in) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // Output slot: a completion may reuse a slot that is being
        // consumed on the same edge, otherwise the new word is dropped.
        if (word_done) begin
            if (!valid_r || out_ready) begin
                q_nx     = shift_r;
                valid_nx = 1'b1;
            end else begin
                overrun_nx = 1'b1;
            end
        end else if (valid_r && out_ready) begin
            valid_nx = 1'b0;
        end

        busy_nx = (state_nx != IDLE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            shift_r     <= '0;
            mode_r      <= 1'b0;
            q_r         <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            shift_r     <= shift_nx;
            mode_r      <= mode_nx;
            q_r         <= q_nx;
            valid_r     <= valid_nx;
            frame_err_r <= frame_err_nx;
            overrun_r   <= overrun_nx;
            busy_r      <= busy_nx;
        end
    end

    assign parallel_Q = q_r;
    assign out_valid  = valid_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_receiver
// Description : Self-checking bench for serial_word_receiver (WIDTH = 4).
//               A table of whole-frame records plus hand-written sequences
//               for reset, same-edge consume/load, line break and sparse
//               strobing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_receiver;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             serial_in;
    logic             bit_en;
    logic             lsb_first;
    logic [WIDTH-1:0] parallel_Q;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    int n_total;
    int n_pass;

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .lsb_first  (lsb_first),
        .parallel_Q (parallel_Q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lsb;
        logic [3:0] word;
        logic       stop;
        logic       rdy;
        logic [3:0] exp_q;
        logic       exp_v;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are settled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one serial bit, preceded by 'gap' non-strobe cycles that carry
    // the inverted bit so that sampling on them would corrupt the word.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bit_en    = 1'b0;
            serial_in = ~b;
            step();
        end
        bit_en    = 1'b1;
        serial_in = b;
        step();
    endtask

    task automatic send_frame(input logic lsb, input logic [3:0] word, input logic stop,
                              input logic rdy_frame, input logic rdy_stop, input int gap);
        lsb_first = lsb;
        out_ready = rdy_frame;
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) begin
            send_bit(lsb ? word[i] : word[3-i], gap);
        end
        out_ready = rdy_stop;
        send_bit(stop, gap);
        out_ready = 1'b0;
    endtask

    task automatic drain();
        bit_en    = 1'b0;
        serial_in = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b0;
        serial_in = 1'b1;
        bit_en    = 1'b0;
        lsb_first = 1'b1;
        out_ready = 1'b0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 2; i++) begin
            serial_in = 1'($urandom);
            bit_en    = 1'($urandom);
            lsb_first = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        check("rst_q",     32'(parallel_Q), 32'd0);
        check("rst_valid", 32'(out_valid),  32'd0);
        check("rst_fe",    32'(frame_err),  32'd0);
        check("rst_ov",    32'(overrun),    32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        rst       = 1'b1;
        serial_in = 1'b1;
        bit_en    = 1'b0;
        out_ready = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        // ---------------- reset in the middle of DATA ----------------
        lsb_first = 1'b1;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("mid_busy", 32'(busy), 32'd1);
        rst       = 1'b0;
        serial_in = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("mid_no_valid", 32'(out_valid), 32'd0);
        send_frame(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 0);
        check("mid_clean_q",     32'(parallel_Q), 32'h9);
        check("mid_clean_valid", 32'(out_valid),  32'd1);
        drain();

        // ---------------- table-driven frames ----------------
        //             lsb   word   stop  rdy   exp_q  v     fe    ov
        vecs[0] = '{1'b1, 4'hB, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'hC, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'h5, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'hA, 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'h6, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].lsb, vecs[v].word, vecs[v].stop, vecs[v].rdy, vecs[v].rdy, 0);
            check($sformatf("vec%0d_q", v),     32'(parallel_Q), 32'(vecs[v].exp_q));
            check($sformatf("vec%0d_valid", v), 32'(out_valid),  32'(vecs[v].exp_v));
            check($sformatf("vec%0d_fe", v),    32'(frame_err),  32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_ov", v),    32'(overrun),    32'(vecs[v].exp_ov));
            // One idle-high strobe: pulses must be gone, BREAK must be left.
            out_ready = 1'b0;
            send_bit(1'b1, 0);
            check($sformatf("vec%0d_fe_pulse", v), 32'(frame_err), 32'd0);
            check($sformatf("vec%0d_ov_pulse", v), 32'(overrun),   32'd0);
            check($sformatf("vec%0d_busy", v),     32'(busy),      32'd0);
        end
        drain();

        // ---------------- MSB first, lsb_first toggled mid-frame ----------------
        lsb_first = 1'b0;
        send_bit(1'b0, 0);
        lsb_first = 1'b1;
        send_bit(1'b1, 0);
        lsb_first = 1'b0;
        send_bit(1'b0, 0);
        lsb_first = 1'b1;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("toggle_q",     32'(parallel_Q), 32'hB);
        check("toggle_valid", 32'(out_valid),  32'd1);
        drain();

        // ---------------- consume and load on the same edge ----------------
        send_frame(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 0);
        check("same_first_q", 32'(parallel_Q), 32'h5);
        lsb_first = 1'b1;
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        check("same_pre_stop_q",     32'(parallel_Q), 32'h5);
        check("same_pre_stop_valid", 32'(out_valid),  32'd1);
        out_ready = 1'b1;
        send_bit(1'b1, 0);
        out_ready = 1'b0;
        check("same_q",     32'(parallel_Q), 32'hA);
        check("same_valid", 32'(out_valid),  32'd1);
        check("same_ov",    32'(overrun),    32'd0);
        drain();

        // ---------------- frame error and line break ----------------
        send_frame(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 0);
        check("brk_fe",    32'(frame_err), 32'd1);
        check("brk_valid", 32'(out_valid), 32'd0);
        check("brk_busy",  32'(busy),      32'd1);
        send_bit(1'b0, 0);
        check("brk_fe_pulse", 32'(frame_err), 32'd0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        check("brk_hold_busy",  32'(busy),      32'd1);
        check("brk_hold_fe",    32'(frame_err), 32'd0);
        check("brk_hold_valid", 32'(out_valid), 32'd0);
        send_bit(1'b1, 0);
        check("brk_exit_busy", 32'(busy), 32'd0);
        send_frame(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 0);
        check("brk_next_q",     32'(parallel_Q), 32'h3);
        check("brk_next_valid", 32'(out_valid),  32'd1);
        check("brk_next_fe",    32'(frame_err),  32'd0);
        drain();

        // ---------------- sparse strobe, one bit every 3 clocks ----------------
        send_frame(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 2);
        check("sparse_q",     32'(parallel_Q), 32'h9);
        check("sparse_valid", 32'(out_valid),  32'd1);
        check("sparse_fe",    32'(frame_err),  32'd0);
        bit_en = 1'b0;
        step();
        check("sparse_busy", 32'(busy), 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
